// File: rtl/top_pkg.sv
// Shared definitions for the bus/ALU subsystem: register map, opcodes, FSM states
// and the single Booth iteration used by the multiplier.
package top_pkg;

   localparam logic [7:0] ADDR_OPA    = 8'h30;
   localparam logic [7:0] ADDR_OPB    = 8'h31;
   localparam logic [7:0] ADDR_OPCODE = 8'h32;
   localparam logic [7:0] ADDR_CTRL   = 8'h33;
   localparam logic [7:0] ADDR_STATUS = 8'h34;
   localparam logic [7:0] ADDR_RES_HI = 8'h35;
   localparam logic [7:0] ADDR_RES_LO = 8'h36;

   typedef enum logic [3:0] {
      OP_NOT_A = 4'h0,
      OP_NOT_B = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_XNOR  = 4'h5,
      OP_ADD   = 4'h6,
      OP_SUB   = 4'h7,
      OP_SLL   = 4'h8,
      OP_SRL   = 4'h9,
      OP_SRA   = 4'hA,
      OP_PASSA = 4'hB,
      OP_PASSB = 4'hC,
      OP_MUL   = 4'hD,
      OP_RSV_E = 4'hE,
      OP_RSV_F = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL
   } state_t;

   // 33-bit accumulator keeps the -2^31 multiplicand from overflowing on subtract
   typedef struct packed {
      logic [32:0] acc;
      logic [31:0] q;
      logic        q1;
   } booth_t;

   function automatic booth_t booth_step(input booth_t s, input logic [31:0] m);
      logic [32:0] mx;
      logic [32:0] sum;
      booth_t      r;
      mx = {m[31], m};
      case ({s.q[0], s.q1})
         2'b01:   sum = s.acc + mx;
         2'b10:   sum = s.acc - mx;
         default: sum = s.acc;
      endcase
      r.acc = {sum[32], sum[32:1]};
      r.q   = {sum[0], s.q[31:1]};
      r.q1  = s.q[0];
      return r;
   endfunction

endpackage

// File: rtl/booth_mul.sv
// Iterative radix-2 Booth multiplier, signed 32x32 -> 64, one iteration per clock.
module booth_mul
   import top_pkg::*;
#(
   parameter int unsigned MUL_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   localparam int unsigned CW = $clog2(MUL_STEPS + 1);

   booth_t        st;
   logic [31:0]   mcand;
   logic [CW-1:0] cnt;

   // First iteration is folded into the load so the whole multiply spans MUL_STEPS clocks
   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= '0;
         mcand <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            st    <= booth_step({33'd0, b, 1'b0}, a);
            mcand <= a;
            cnt   <= CW'(MUL_STEPS - 1);
            busy  <= 1'b1;
         end else if (busy) begin
            st  <= booth_step(st, mcand);
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = {st.acc[31:0], st.q};

endmodule

// File: rtl/top.sv
// Single-master bus subsystem: registered grant, RAM, memory-mapped ALU registers
// and an iterative Booth multiplier.
module top
   import top_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 32,
   parameter int unsigned MUL_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        M_req,
   input  logic        M_wr,
   input  logic [7:0]  M_addr,
   input  logic [31:0] M_dout,
   output logic        M_grant,
   output logic [31:0] M_din
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] op_a, op_b, lat_a, lat_b, res_hi, res_lo, rd_data, alu_y;
   logic [3:0]  opcode;
   opcode_t     lat_op;
   logic        busy, done;
   logic        access, wr_en, rd_en, in_ram, start_req;
   logic        accept, mul_start, exec_fin, mul_fin;
   logic        mul_busy, mul_done;
   logic [63:0] mul_p;
   state_t      state, state_nx;

   assign access    = M_grant & M_req;
   assign wr_en     = access & M_wr;
   assign rd_en     = access & ~M_wr;
   assign in_ram    = M_addr < 8'(RAM_WORDS);
   assign start_req = wr_en && (M_addr == ADDR_CTRL) && M_dout[0];

   always_ff @(posedge clk) begin
      if (reset_n) begin
         M_grant <= 1'b0;
         M_din   <= '0;
      end else begin
         M_grant <= M_req;
         M_din   <= rd_en ? rd_data : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && in_ram) ram[M_addr[AW-1:0]] <= M_dout;
   end

   always_comb begin
      rd_data = '0;
      if (in_ram) begin
         rd_data = ram[M_addr[AW-1:0]];
      end else begin
         case (M_addr)
            ADDR_OPA:    rd_data = op_a;
            ADDR_OPB:    rd_data = op_b;
            ADDR_OPCODE: rd_data = {28'd0, opcode};
            ADDR_STATUS: rd_data = {30'd0, done, busy};
            ADDR_RES_HI: rd_data = res_hi;
            ADDR_RES_LO: rd_data = res_lo;
            default:     rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      mul_start = 1'b0;
      exec_fin  = 1'b0;
      mul_fin   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_req && !mul_busy) begin
               accept = 1'b1;
               if (opcode_t'(opcode) == OP_MUL) begin
                  mul_start = 1'b1;
                  state_nx  = S_MUL;
               end else begin
                  state_nx = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            exec_fin = 1'b1;
            state_nx = S_IDLE;
         end
         S_MUL: begin
            if (mul_done) begin
               mul_fin  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         op_a   <= '0;
         op_b   <= '0;
         opcode <= '0;
         lat_a  <= '0;
         lat_b  <= '0;
         lat_op <= OP_NOT_A;
         res_hi <= '0;
         res_lo <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (wr_en) begin
            case (M_addr)
               ADDR_OPA:    op_a   <= M_dout;
               ADDR_OPB:    op_b   <= M_dout;
               ADDR_OPCODE: opcode <= M_dout[3:0];
               default: ;
            endcase
         end
         if (accept) begin
            lat_a  <= op_a;
            lat_b  <= op_b;
            lat_op <= opcode_t'(opcode);
            busy   <= 1'b1;
            done   <= 1'b0;
         end
         if (exec_fin) begin
            res_hi <= '0;
            res_lo <= alu_y;
            busy   <= 1'b0;
            done   <= 1'b1;
         end
         if (mul_fin) begin
            {res_hi, res_lo} <= mul_p;
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   always_comb begin
      alu_y = '0;
      case (lat_op)
         OP_NOT_A: alu_y = ~lat_a;
         OP_NOT_B: alu_y = ~lat_b;
         OP_AND:   alu_y = lat_a & lat_b;
         OP_OR:    alu_y = lat_a | lat_b;
         OP_XOR:   alu_y = lat_a ^ lat_b;
         OP_XNOR:  alu_y = ~(lat_a ^ lat_b);
         OP_ADD:   alu_y = lat_a + lat_b;
         OP_SUB:   alu_y = lat_a - lat_b;
         OP_SLL:   alu_y = lat_a << lat_b[4:0];
         OP_SRL:   alu_y = lat_a >> lat_b[4:0];
         OP_SRA:   alu_y = $unsigned($signed(lat_a) >>> lat_b[4:0]);
         OP_PASSA: alu_y = lat_a;
         OP_PASSB: alu_y = lat_b;
         default:  alu_y = '0;
      endcase
   end

   booth_mul #(
      .MUL_STEPS(MUL_STEPS)
   ) u_mul (
      .clk    (clk),
      .reset  (reset_n),
      .start  (mul_start),
      .a      (op_a),
      .b      (op_b),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(mul_p)
   );

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: reads push expected data, a monitor compares M_din
// on the clock after each read access seen on the bus.
module tb_top;
   import top_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        M_req, M_wr, M_grant;
   logic [7:0]  M_addr;
   logic [31:0] M_dout, M_din;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
      bit          chk;
   } exp_t;

   exp_t sb[$];
   bit   rd_pend  = 1'b0;
   bit   idle_chk = 1'b0;

   top #(
      .RAM_WORDS(32),
      .MUL_STEPS(32)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .M_req  (M_req),
      .M_wr   (M_wr),
      .M_addr (M_addr),
      .M_dout (M_dout),
      .M_grant(M_grant),
      .M_din  (M_din)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_pend = M_grant & M_req & ~M_wr;

   always @(negedge clk) begin
      exp_t e;
      if (rd_pend) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read: got %h want no read", M_din);
         end else begin
            e = sb.pop_front();
            if (e.chk) check(e.name, M_din, e.exp);
         end
      end else if (idle_chk) begin
         check("din_idle", M_din, 32'h0);
      end
   end

   // Idle bus cycles park on a write to an unmapped address
   task automatic park();
      M_wr = 1'b1; M_addr = 8'hFF; M_dout = 32'h0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      M_wr = 1'b1; M_addr = a; M_dout = d;
      @(negedge clk);
      park();
   endtask

   task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string name,
                         input bit chk = 1'b1);
      exp_t e;
      e.name = name; e.exp = exp; e.chk = chk;
      sb.push_back(e);
      M_wr = 1'b0; M_addr = a;
      @(negedge clk);
      park();
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         bus_rd(ADDR_STATUS, 32'h0, "poll", 1'b0);
         n++;
      end while (M_din !== 32'h2 && n < 40);
      check({name, "_done"}, M_din, 32'h2);
      checks++;
      if (n > 34) begin
         failures++;
         $display("FAIL %s_latency: got %0d polls want <=34", name, n);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] hi, input logic [31:0] lo, input string name);
      bus_wr(ADDR_OPA, a);
      bus_wr(ADDR_OPB, b);
      bus_wr(ADDR_OPCODE, {28'h0, op});
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, 32'h1, {name, "_busy"});
      wait_done(name);
      bus_rd(ADDR_RES_LO, lo, {name, "_lo"});
      bus_rd(ADDR_RES_HI, hi, {name, "_hi"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want TB_RESULT");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b1; M_req = 1'b0; M_wr = 1'b0; M_addr = 8'h0; M_dout = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_grant", {31'd0, M_grant}, 32'h0);
      check("rst_din", M_din, 32'h0);
      reset_n = 1'b0;
      idle_chk = 1'b1;
      M_req = 1'b1;
      park();
      @(negedge clk);
      check("grant_on", {31'd0, M_grant}, 32'h1);
      bus_rd(ADDR_STATUS, 32'h0, "rst_status");
      bus_rd(ADDR_RES_LO, 32'h0, "rst_res_lo");
      bus_rd(ADDR_OPA, 32'h0, "rst_opa");

      bus_wr(8'h00, 32'h2);
      bus_wr(8'h01, 32'h3);
      bus_rd(8'h00, 32'h2, "ram0");
      bus_rd(8'h01, 32'h3, "ram1");
      bus_wr(8'h1F, 32'hCAFE_F00D);
      bus_rd(8'h1F, 32'hCAFE_F00D, "ram31");

      run_op(32'h5,        32'h16,       4'hD, 32'h0,        32'h6E,       "mul_5x22");
      run_op(32'hFFFFFFFD, 32'h7,        4'hD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul_m3x7");
      run_op(32'hFFFFFFFF, 32'h1,        4'h6, 32'h0,        32'h0,        "add_wrap");
      run_op(32'h80000000, 32'h80000000, 4'hD, 32'h40000000, 32'h0,        "mul_min_min");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hD, 32'h0,        32'h1,        "mul_m1xm1");
      run_op(32'h7FFFFFFF, 32'h80000000, 4'hD, 32'hC0000000, 32'h80000000, "mul_max_min");
      run_op(32'h3,        32'h5,        4'h7, 32'h0,        32'hFFFFFFFE, "sub");
      run_op(32'h0F0F1234, 32'h0,        4'h0, 32'h0,        32'hF0F0EDCB, "not_a");
      run_op(32'h1,        32'h0,        4'h1, 32'h0,        32'hFFFFFFFF, "not_b");
      run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'h2, 32'h0,        32'hF000F000, "and");
      run_op(32'h0F0F0F0F, 32'h00FF00FF, 4'h3, 32'h0,        32'h0FFF0FFF, "or");
      run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'h4, 32'h0,        32'h0FF00FF0, "xor");
      run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'h5, 32'h0,        32'hF00FF00F, "xnor");
      run_op(32'h1,        32'h25,       4'h8, 32'h0,        32'h20,       "sll");
      run_op(32'h80000000, 32'h4,        4'h9, 32'h0,        32'h08000000, "srl");
      run_op(32'h80000000, 32'h4,        4'hA, 32'h0,        32'hF8000000, "sra");
      run_op(32'h12345678, 32'h0,        4'hB, 32'h0,        32'h12345678, "pass_a");
      run_op(32'h0,        32'h9ABCDEF0, 4'hC, 32'h0,        32'h9ABCDEF0, "pass_b");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hE, 32'h0,        32'h0,        "op_e");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h0,        "op_f");
      bus_wr(ADDR_OPCODE, 32'hFFFFFFF7);
      bus_rd(ADDR_OPCODE, 32'h7, "opcode_rb");

      // Operand changes and a second start during a multiply must not disturb it
      bus_wr(ADDR_OPA, 32'h5);
      bus_wr(ADDR_OPB, 32'h16);
      bus_wr(ADDR_OPCODE, 32'hD);
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, 32'h1, "lat_busy");
      bus_wr(ADDR_OPA, 32'h9);
      bus_wr(ADDR_OPCODE, 32'h6);
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, 32'h1, "restart_ignored");
      bus_rd(ADDR_CTRL, 32'h0, "ctrl_reads0");
      wait_done("latch");
      bus_rd(ADDR_RES_LO, 32'h6E, "latch_lo");
      bus_rd(ADDR_RES_HI, 32'h0, "latch_hi");
      bus_rd(ADDR_OPA, 32'h9, "opa_rb");

      // Reset in the middle of a multiply
      bus_wr(ADDR_OPA, 32'h7);
      bus_wr(ADDR_OPB, 32'h7);
      bus_wr(ADDR_OPCODE, 32'hD);
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, 32'h1, "abort_busy");
      repeat (5) @(negedge clk);
      M_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      check("mid_rst_grant", {31'd0, M_grant}, 32'h0);
      M_req = 1'b1;
      @(negedge clk);
      bus_rd(ADDR_STATUS, 32'h0, "abort_status");
      bus_rd(ADDR_RES_LO, 32'h0, "abort_lo");
      bus_rd(ADDR_RES_HI, 32'h0, "abort_hi");
      repeat (40) @(negedge clk);
      bus_rd(ADDR_STATUS, 32'h0, "abort_stays_idle");
      bus_rd(ADDR_RES_LO, 32'h0, "abort_lo_late");
      run_op(32'h0, 32'h00001234, 4'hC, 32'h0, 32'h00001234, "post_rst");

      // No access without request; unmapped addresses
      M_req = 1'b0;
      @(negedge clk);
      check("grant_drop", {31'd0, M_grant}, 32'h0);
      M_wr = 1'b1; M_addr = 8'h00; M_dout = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      check("no_req_grant", {31'd0, M_grant}, 32'h0);
      park();
      M_req = 1'b1;
      @(negedge clk);
      bus_rd(8'h00, 32'h2, "ram0_kept");
      bus_rd(8'h80, 32'h0, "unmapped_80");
      bus_wr(8'h40, 32'h12345678);
      bus_rd(8'h40, 32'h0, "unmapped_40");
      bus_rd(8'h01, 32'h3, "ram1_kept");

      M_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
